// File: rtl/wb_burst_ram.sv
// Wishbone RAM with byte enables and incrementing bursts. Read data and ack/err are registered one cycle after the accepting edge.
// Bursts ack every cycle the master keeps cyc&stb high. Dropping cyc or stb ends the burst. There is no wait-state insertion.
module wb_burst_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  parameter int ADR_W  = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADR_W-1:0]    wb_adr_i,
  input  logic [DATA_W/8-1:0] wb_sel_i,
  input  logic [2:0]          wb_cti_i,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic                wb_ack_o,
  output logic                wb_err_o
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADR_W:0] DEPTH_A = (ADR_W + 1)'(DEPTH);
  localparam logic [ADR_W:0] ADR_ONE = {{ADR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CLASSIC_ACK, BURST} state_t;

  state_t              state;
  logic [ADR_W:0]      cnt;
  logic                ack_q;
  logic                err_q;
  logic                req;
  logic                beat;
  logic                oor;
  logic                wr_en;
  logic [ADR_W:0]      acc_adr;
  logic [DATA_W-1:0]   rd_word;

  // Contents come up as zero from configuration; rst_i never touches them.
  logic [DATA_W-1:0]   mem [DEPTH];

  // The counter is one bit wider than the address so running off the end reads as out-of-range, never as a wrap to 0.
  always_comb begin
    req     = wb_cyc_i & wb_stb_i;
    acc_adr = (state == BURST) ? cnt : {1'b0, wb_adr_i};
    oor     = (acc_adr >= DEPTH_A);
    beat    = req & (state != CLASSIC_ACK);
    wr_en   = beat & wb_we_i & ~oor & ~rst_i;
    rd_word = oor ? '0 : mem[acc_adr[ADR_W-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (wb_sel_i[k]) mem[acc_adr[ADR_W-1:0]][8*k +: 8] <= wb_dat_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (oor) begin
              err_q    <= 1'b1;
              wb_dat_o <= '0;
            end else begin
              ack_q <= 1'b1;
              if (!wb_we_i) wb_dat_o <= rd_word;
              if (wb_cti_i == 3'b010) begin
                state <= BURST;
                cnt   <= acc_adr + ADR_ONE;
              end else begin
                state <= CLASSIC_ACK;
              end
            end
          end
        end
        CLASSIC_ACK: state <= IDLE;
        BURST: begin
          if (!req) begin
            state <= IDLE;
          end else if (oor) begin
            err_q    <= 1'b1;
            wb_dat_o <= '0;
            state    <= IDLE;
          end else begin
            ack_q <= 1'b1;
            if (!wb_we_i) wb_dat_o <= rd_word;
            cnt <= cnt + ADR_ONE;
            if (wb_cti_i != 3'b010) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wb_ack_o = ack_q & wb_cyc_i;
  assign wb_err_o = err_q & wb_cyc_i;

endmodule
